// File: rtl/wb_cmd_initiator_if.sv
// Command, response and Wishbone signal bundle for wb_cmd_initiator.
// Signal suffixes are written from the initiator's point of view.
interface wb_cmd_initiator_if #(
  parameter int ADR_BITS = 11
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_wr_i;
  logic [ADR_BITS-1:0] cmd_adr_i;
  logic [31:0]         cmd_dat_i;
  logic [3:0]          cmd_sel_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [31:0]         rsp_dat_o;
  logic [1:0]          rsp_status_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [ADR_BITS-1:0] wb_adr_o;
  logic [31:0]         wb_dat_o;
  logic [3:0]          wb_sel_o;
  logic [31:0]         wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;
  logic                wb_rty_i;
  logic                busy_o;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  busy_o
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Single-beat Wishbone classic initiator: one command in, one bus cycle with
// bounded retry and per-attempt timeout, one status/data response out.
module wb_cmd_initiator #(
  parameter int ADR_BITS       = 11,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_cmd_initiator_if.master bus
);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [1:0] ST_ACK = 2'b00, ST_ERR = 2'b01, ST_TMO = 2'b10, ST_RTY = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_e;

  typedef struct packed {
    logic                we;
    logic [ADR_BITS-1:0] adr;
    logic [31:0]         dat;
    logic [3:0]          sel;
  } wb_req_t;

  state_e        state_q;
  wb_req_t       req_q;
  logic          cyc_q, stb_q, cmd_ready_q, rsp_valid_q, busy_q;
  logic [31:0]   rsp_dat_q;
  logic [1:0]    rsp_status_q;
  logic [RW-1:0] rty_cnt_q;
  logic [15:0]   to_cnt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
      rty_cnt_q    <= '0;
      to_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_ready_q && bus.cmd_valid_i) begin
            req_q       <= '{we: bus.cmd_wr_i, adr: bus.cmd_adr_i,
                             dat: bus.cmd_dat_i, sel: bus.cmd_sel_i};
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rty_cnt_q   <= '0;
            to_cnt_q    <= '0;
            state_q     <= BUS;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        // Termination priority: ack > err > rty > timeout.
        BUS: begin
          if (bus.wb_ack_i) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            rsp_dat_q    <= req_q.we ? '0 : bus.wb_dat_i;
            rsp_status_q <= ST_ACK;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (bus.wb_err_i) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_ERR;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (bus.wb_rty_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            if (rty_cnt_q < RW'(MAX_RETRIES)) begin
              rty_cnt_q <= rty_cnt_q + 1'b1;
              state_q   <= GAP;
            end else begin
              rsp_dat_q    <= '0;
              rsp_status_q <= ST_RTY;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_TMO;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        // One idle bus cycle between a retry and its reissue.
        GAP: begin
          cyc_q    <= 1'b1;
          stb_q    <= 1'b1;
          to_cnt_q <= '0;
          state_q  <= BUS;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = stb_q;
  assign bus.wb_we_o      = req_q.we;
  assign bus.wb_adr_o     = req_q.adr;
  assign bus.wb_dat_o     = req_q.dat;
  assign bus.wb_sel_o     = req_q.sel;
  assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed and randomized bench for wb_cmd_initiator with a scripted target
// and an attempt-level reference model of status, data and bus timing.
module tb_wb_cmd_initiator;
  localparam int AB = 11;
  localparam int TO = 16;
  localparam int MR = 2;
  // target script entry types
  localparam int T_NONE = 0, T_ACK = 1, T_ERR = 2, T_RTY = 3, T_ACKERR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_cmd_initiator_if #(.ADR_BITS(AB)) bus();

  wb_cmd_initiator #(.ADR_BITS(AB), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  int nchk = 0;
  int nerr = 0;

  int att_type[8];
  int att_dly[8];
  int att_idx, tcnt, run, gap_run, n_pulses, ty;
  int pulse_len[8];
  int gap_len[8];
  int exp_plen[8];
  logic prev_stb = 1'b0;
  logic [31:0] tgt_rdata;
  logic seen_any, fld_stable, seen_we;
  logic [AB-1:0] seen_adr;
  logic [31:0] seen_dat;
  logic [3:0] seen_sel;

  // Scripted target plus stb-pulse monitor, all on the falling edge.
  always @(negedge clk) begin
    if (bus.wb_stb_o) begin
      if (!prev_stb) begin
        tcnt = 0;
        if (n_pulses > 0 && n_pulses < 8) gap_len[n_pulses] = gap_run;
      end
      ty = (att_idx < 8) ? att_type[att_idx] : T_NONE;
      bus.wb_ack_i = (att_idx < 8) && (tcnt == att_dly[att_idx]) && (ty == T_ACK || ty == T_ACKERR);
      bus.wb_err_i = (att_idx < 8) && (tcnt == att_dly[att_idx]) && (ty == T_ERR || ty == T_ACKERR);
      bus.wb_rty_i = (att_idx < 8) && (tcnt == att_dly[att_idx]) && (ty == T_RTY);
      tcnt++;
      run++;
      if (!seen_any) begin
        seen_any = 1'b1;
        seen_we  = bus.wb_we_o;
        seen_adr = bus.wb_adr_o;
        seen_dat = bus.wb_dat_o;
        seen_sel = bus.wb_sel_o;
      end else if (seen_we !== bus.wb_we_o || seen_adr !== bus.wb_adr_o ||
                   seen_dat !== bus.wb_dat_o || seen_sel !== bus.wb_sel_o) begin
        fld_stable = 1'b0;
      end
    end else begin
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_rty_i = 1'b0;
      if (prev_stb) begin
        if (n_pulses < 8) pulse_len[n_pulses] = run;
        n_pulses++;
        att_idx++;
        run = 0;
        gap_run = 0;
      end
      gap_run++;
    end
    bus.wb_dat_i = tgt_rdata;
    prev_stb = bus.wb_stb_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    att_idx = 0; n_pulses = 0; run = 0; gap_run = 0;
    seen_any = 1'b0; fld_stable = 1'b1;
  endtask

  task automatic set_att(input int a, input int t, input int d);
    att_type[a] = t;
    att_dly[a]  = d;
  endtask

  // Attempt-level view: each attempt lasts dly+1 stb cycles (or TO if the
  // target stays silent), retries add one idle cycle, the response shows up
  // one cycle after the final attempt.
  task automatic model(input logic wr, input logic [31:0] rd, output logic [1:0] st,
                       output logic [31:0] dt, output int np, output int lat);
    st = 2'b00; dt = '0; np = 0; lat = 0;
    for (int a = 0; a <= MR; a++) begin
      if (att_type[a] == T_NONE || att_dly[a] >= TO) begin
        exp_plen[np++] = TO; lat += TO; st = 2'b10; break;
      end
      exp_plen[np++] = att_dly[a] + 1;
      lat += att_dly[a] + 1;
      if (att_type[a] == T_ACK || att_type[a] == T_ACKERR) begin
        st = 2'b00; dt = wr ? 32'h0 : rd; break;
      end
      if (att_type[a] == T_ERR) begin st = 2'b01; break; end
      if (a == MR) begin st = 2'b11; break; end
      lat += 1;
    end
    lat += 1;
  endtask

  task automatic issue(input logic wr, input logic [AB-1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int k;
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_wr_i    = wr;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    k = 0;
    while (!bus.cmd_ready_o && k < 50) begin @(negedge clk); k++; end
    chk("cmd_ready_before_accept", 32'(bus.cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic run_txn(input string nm, input logic wr, input logic [AB-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int bp_cycles);
    logic [1:0] est;
    logic [31:0] edat, hold_dat;
    logic [1:0] hold_st;
    int enp, elat, lat;
    logic stable;
    model(wr, tgt_rdata, est, edat, enp, elat);
    bus.rsp_ready_i = (bp_cycles == 0);
    issue(wr, adr, dat, sel);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid_o && lat < 2000);
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_status"}, 32'(bus.rsp_status_o), 32'(est));
    chk({nm, "_rdat"}, bus.rsp_dat_o, edat);
    chk({nm, "_cmd_ready_low"}, {bus.cmd_ready_o, bus.busy_o, bus.wb_cyc_o}, 32'b010);
    if (bp_cycles > 0) begin
      hold_dat = bus.rsp_dat_o;
      hold_st  = bus.rsp_status_o;
      stable   = 1'b1;
      repeat (bp_cycles) begin
        @(negedge clk);
        if (!bus.rsp_valid_o || bus.cmd_ready_o || bus.rsp_dat_o !== hold_dat ||
            bus.rsp_status_o !== hold_st) stable = 1'b0;
      end
      chk({nm, "_bp_stable"}, 32'(stable), 32'd1);
      bus.rsp_ready_i = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_after_hs"}, {bus.rsp_valid_o, bus.cmd_ready_o, bus.busy_o}, 32'b010);
    chk({nm, "_npulses"}, 32'(n_pulses), 32'(enp));
    for (int i = 0; i < enp && i < 8; i++) begin
      chk({nm, "_plen"}, 32'(pulse_len[i]), 32'(exp_plen[i]));
      if (i > 0) chk({nm, "_gap"}, 32'(gap_len[i]), 32'd1);
    end
    chk({nm, "_wb_fields"}, {31'd0, fld_stable}, 32'd1);
    chk({nm, "_wb_adr_we_sel"}, {16'd0, seen_sel, seen_we, seen_adr}, {16'd0, sel, wr, adr});
    chk({nm, "_wb_dat"}, seen_dat, dat);
  endtask

  initial begin
    logic [31:0] r;
    bus.cmd_valid_i = 1'b0; bus.cmd_wr_i = 1'b0; bus.cmd_adr_i = '0;
    bus.cmd_dat_i = '0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b1;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
    tgt_rdata = '0;
    for (int i = 0; i < 8; i++) set_att(i, T_NONE, 0);
    clear_mon();

    // reset state
    #3;
    chk("reset_outputs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o}, 32'd0);
    chk("reset_rsp", {bus.rsp_status_o, bus.rsp_dat_o[29:0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk);
    chk("ready_first_edge", 32'(bus.cmd_ready_o), 32'd1);

    // write acked on the 2nd stb cycle
    set_att(0, T_ACK, 1);
    run_txn("wr_ack", 1'b1, 11'h00C, 32'h0100_0000, 4'hF, 0);

    // read returning ID word
    tgt_rdata = 32'h5355_5246;
    set_att(0, T_ACK, 1);
    run_txn("rd_id", 1'b0, 11'h000, 32'h0, 4'hF, 0);

    // ack and err together, then err alone
    set_att(0, T_ACKERR, 0);
    run_txn("rd_ackerr", 1'b0, 11'h004, 32'h0, 4'hF, 0);
    set_att(0, T_ERR, 0);
    run_txn("rd_err", 1'b0, 11'h008, 32'h0, 4'hF, 0);

    // retry then ack; retries exhausted
    set_att(0, T_RTY, 0); set_att(1, T_RTY, 0); set_att(2, T_ACK, 1);
    run_txn("rty_ack", 1'b0, 11'h010, 32'h0, 4'h3, 0);
    set_att(0, T_RTY, 0); set_att(1, T_RTY, 1); set_att(2, T_RTY, 2);
    run_txn("rty_exh", 1'b1, 11'h014, 32'hCAFE_F00D, 4'hC, 0);

    // silent target then a normal command
    set_att(0, T_NONE, 0);
    run_txn("timeout", 1'b0, 11'h020, 32'h0, 4'hF, 0);
    set_att(0, T_ACK, 0);
    run_txn("after_tmo", 1'b1, 11'h024, 32'h1234_5678, 4'h1, 0);

    // response backpressure
    tgt_rdata = 32'hA5A5_0F0F;
    set_att(0, T_ACK, 2);
    run_txn("backpress", 1'b0, 11'h028, 32'h0, 4'hF, 10);

    // reset in the middle of a bus cycle
    set_att(0, T_NONE, 0);
    issue(1'b1, 11'h030, 32'hDEAD_BEEF, 4'hF);
    repeat (3) @(negedge clk);
    chk("midbus_cyc_high", {bus.wb_cyc_o, bus.wb_stb_o}, 32'b11);
    #2 rst_n = 1'b0;
    #1 chk("midbus_async_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o, bus.cmd_ready_o}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midbus_no_rsp", {bus.rsp_valid_o, bus.wb_stb_o}, 32'd0);
    end
    rst_n = 1'b1;
    #1 chk("rerelease_ready_low", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk);
    chk("rerelease_ready_high", {bus.cmd_ready_o, bus.rsp_valid_o}, 32'b10);

    // randomized commands and target behaviour
    for (int n = 0; n < 24; n++) begin
      for (int a = 0; a < 8; a++) begin
        r = $urandom_range(0, 15);
        set_att(a, (r == 0) ? T_NONE : (r < 6) ? T_ACK : (r < 8) ? T_ERR :
                   (r < 10) ? T_ACKERR : T_RTY, $urandom_range(0, 4));
      end
      tgt_rdata = $urandom;
      run_txn("rand", 1'($urandom_range(0, 1)), AB'($urandom), $urandom, 4'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic initiator that drives single-beat transactions into 32-bit targets such as the SURF ID/control register block.
- Commands enter on a valid/ready port. Each one runs as one Wishbone cycle, with bounded retry and a timeout.
- The result leaves on a valid/ready response port.
- Used as the local bus master behind the housekeeping command path.

Parameters:
ADR_BITS, 11, width of wb_adr_o / cmd_adr_i
TIMEOUT_CYCLES, 256, maximum cycles stb is held high per attempt before abort (range 2..65535)
MAX_RETRIES, 3, number of reissues allowed after a rty termination (0 = no reissue)

Ports:
wb_clk_i  in  1  single clock for the whole block
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  block accepts a command this cycle
cmd_wr_i  in  1  1 = write, 0 = read
cmd_adr_i  in  ADR_BITS  byte address
cmd_dat_i  in  32  write data
cmd_sel_i  in  4  byte selects
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed
rsp_dat_o  out  32  read data (0 for writes and for failed reads)
rsp_status_o  out  2  00 ack, 01 err, 10 timeout, 11 retries exhausted
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADR_BITS  address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects
wb_dat_i  in  32  read data
wb_ack_i  in  1  normal termination
wb_err_i  in  1  error termination
wb_rty_i  in  1  retry termination
busy_o  out  1  state != IDLE

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - state = IDLE.
  - All outputs 0, including cmd_ready_o.
  - Latched command, retry counter and timeout counter cleared.
  - An in-flight cycle is abandoned immediately: cyc/stb fall asynchronously and no response is produced.
- All outputs are registered.
- cmd_ready_o = 1 only in IDLE. It rises on the first edge after reset release.
- States:
  - IDLE → BUS:
    - Triggers on cmd_valid_i & cmd_ready_o at edge N.
    - At that edge: latch we/adr/dat/sel onto the wb_* outputs, set cyc=stb=1, cmd_ready_o=0, clear retry count and timeout count.
    - cyc/stb are high from cycle N+1.
  - BUS: hold all wb_* outputs stable. Each edge samples the terminations with priority ack > err > rty > timeout.
    - ack: cyc=stb=0. rsp_dat_o = wb_dat_i if read, else 0. status 00. Go to RESP.
    - err: cyc=stb=0, rsp_dat_o=0, status 01, go to RESP.
    - rty, retry count < MAX_RETRIES: cyc=stb=0, increment retry count, go to GAP.
    - rty, retry count == MAX_RETRIES: status 11, rsp_dat_o=0, go to RESP.
    - No termination and timeout count == TIMEOUT_CYCLES-1: cyc=stb=0, status 10, rsp_dat_o=0, go to RESP. stb is therefore high for exactly TIMEOUT_CYCLES cycles per attempt.
    - Otherwise increment the timeout count.
  - GAP:
    - One idle bus cycle (cyc=stb=0, address/data held).
    - Then cyc=stb=1, timeout count cleared, go to BUS.
  - RESP:
    - rsp_valid_o=1, with data and status stable until rsp_ready_i is sampled high.
    - On that edge: rsp_valid_o=0, cmd_ready_o=1, go to IDLE.
- Minimum turnaround: at most one command per response. The next command is accepted at the earliest one cycle after the response handshake.
- Latency example, target with a 1-cycle registered ack, rsp_ready_i held high:
  - accept at edge N;
  - stb high N+1;
  - ack seen at edge N+2;
  - rsp_valid_o high in N+3;
  - cmd_ready_o high in N+4.
- Termination inputs are ignored outside BUS.
- wb_dat_o/wb_sel_o/wb_we_o/wb_adr_o keep their last value after the cycle ends. They are don't-care when cyc=0.

Test Plan:
1. Write adr 0x00C, dat 0x0100_0000, sel 0xF; target acks in the 2nd stb cycle → one stb pulse of 2 cycles, we=1; response status 00, dat 0x0000_0000; cmd_ready_o low until 1 cycle after the response handshake.
2. Read adr 0x000; target returns 0x5355_5246 with ack → rsp_dat_o 0x5355_5246, status 00, rsp_valid_o 3 cycles after acceptance.
3. Read with err and ack asserted in the same cycle → status 00 (ack wins). Then a separate read with err only → status 01, dat 0.
4. MAX_RETRIES=2:
   - rty, rty, ack → three stb assertions, each separated by exactly 1 idle cycle, status 00.
   - rty ×3 → three stb assertions, then status 11.
5. TIMEOUT_CYCLES=16, target never responds → stb high for exactly 16 cycles, then status 10, dat 0. A subsequent command is accepted normally.
6. Backpressure and reset:
   - rsp_ready_i held low 10 cycles → rsp_valid_o, data and status stable throughout, and cmd_ready_o stays 0.
   - wb_rst_ni pulsed low mid-BUS → cyc/stb drop without a clock edge, and no response appears.
   - After reset release, cmd_ready_o = 1 on the first edge.
